// File: rtl/issue_queue_dual.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue_dual
//  Purpose  : DEPTH-entry in-order instruction queue between decode and
//             execute. Each cycle it issues up to two of the oldest entries
//             into pipe A (ALU/branch) and pipe B (ALU/memory), with RAW,
//             branch-shadow and pipe-compatibility checks. Issue outputs are
//             registered; stop freezes dequeue and outputs, flush empties the
//             queue and clears the issue valids.
//  Options  : define ISSUE_STATS_EN to add free-running 32-bit issue
//             statistics counters (stat_dual_o, stat_single_o, stat_hazard_o).
//  Revision : 1.0 - initial release
// ============================================================================
module issue_queue_dual #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DEC_W = 72
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stop_i,
    input  logic             flush_i,
    output logic             in_ready_o,
    // decode slot 1 (older)
    input  logic             in1_valid_i,
    input  logic [PC_W-1:0]  in1_pc_i,
    input  logic [DEC_W-1:0] in1_dec_i,
    input  logic [4:0]       in1_rd_i,
    input  logic [4:0]       in1_rs1_i,
    input  logic [4:0]       in1_rs2_i,
    input  logic             in1_we_i,
    input  logic [1:0]       in1_cls_i,
    // decode slot 2 (younger)
    input  logic             in2_valid_i,
    input  logic [PC_W-1:0]  in2_pc_i,
    input  logic [DEC_W-1:0] in2_dec_i,
    input  logic [4:0]       in2_rd_i,
    input  logic [4:0]       in2_rs1_i,
    input  logic [4:0]       in2_rs2_i,
    input  logic             in2_we_i,
    input  logic [1:0]       in2_cls_i,
    // pipe A (ALU / branch)
    output logic             outa_valid_o,
    output logic [PC_W-1:0]  outa_pc_o,
    output logic [DEC_W-1:0] outa_dec_o,
    // pipe B (ALU / memory)
    output logic             outb_valid_o,
    output logic [PC_W-1:0]  outb_pc_o,
    output logic [DEC_W-1:0] outb_dec_o,
    // {dual, hazard, outb_valid, outa_valid}
    output logic [3:0]       issue_flag_o
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_dual_o,
    output logic [31:0]      stat_single_o,
    output logic [31:0]      stat_hazard_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] C_CLS_ALU = 2'd0;
    localparam logic [1:0] C_CLS_BR  = 2'd1;
    localparam logic [1:0] C_CLS_MEM = 2'd2;

    localparam logic [CNT_W-1:0] C_READY_MAX = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_TWO   = CNT_W'(2);
    localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);

    // ------------------------------------------------------------------------
    // Queue storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [PC_W-1:0]  pc_q  [DEPTH];
    logic [DEC_W-1:0] dec_q [DEPTH];
    logic [4:0]       rd_q  [DEPTH];
    logic [4:0]       rs1_q [DEPTH];
    logic [4:0]       rs2_q [DEPTH];
    logic             we_q  [DEPTH];
    logic [1:0]       cls_q [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Registered issue outputs
    logic             outa_valid_q;
    logic [PC_W-1:0]  outa_pc_q;
    logic [DEC_W-1:0] outa_dec_q;
    logic             outb_valid_q;
    logic [PC_W-1:0]  outb_pc_q;
    logic [DEC_W-1:0] outb_dec_q;
    logic [3:0]       issue_flag_q;

    // Selection signals
    logic [PTR_W-1:0] h1_ptr;
    logic             h0_avail;
    logic             h1_avail;
    logic             h0_to_b;
    logic             raw_hit;
    logic             h1_fits;
    logic             co_issue;
    logic             hazard;
    logic             sel_a_valid;
    logic             sel_b_valid;
    logic [PTR_W-1:0] sel_a_ptr;
    logic [PTR_W-1:0] sel_b_ptr;
    logic             issue_en;
    logic [CNT_W-1:0] deq_n;

    // Enqueue signals
    logic             enq_en;
    logic             wr1;
    logic             wr2;
    logic [PTR_W-1:0] wr2_ptr;
    logic [CNT_W-1:0] enq_n;

    assign in_ready_o = (count_q <= C_READY_MAX);

    // Head-pair selection: decide what issues this cycle and to which pipe.
    always_comb begin
        h1_ptr   = head_q + C_PTR_ONE;
        h0_avail = (count_q >= C_CNT_ONE);
        h1_avail = (count_q >= C_CNT_TWO);

        // H0 steers to B only for memory ops; everything else starts in A.
        h0_to_b  = (cls_q[head_q] == C_CLS_MEM);

        // A zero destination never creates a dependency.
        raw_hit  = we_q[head_q] && (rd_q[head_q] != 5'd0) &&
                   ((rs1_q[h1_ptr] == rd_q[head_q]) ||
                    (rs2_q[h1_ptr] == rd_q[head_q]));

        // H1 must be accepted by whichever pipe H0 left free.
        if (h0_to_b) begin
            h1_fits = (cls_q[h1_ptr] == C_CLS_ALU) || (cls_q[h1_ptr] == C_CLS_BR);
        end else begin
            h1_fits = (cls_q[h1_ptr] == C_CLS_ALU) || (cls_q[h1_ptr] == C_CLS_MEM);
        end

        co_issue = h1_avail && !raw_hit &&
                   (cls_q[head_q] != C_CLS_BR) && h1_fits;
        hazard   = h1_avail && !co_issue;

        sel_a_valid = (h0_avail && !h0_to_b) || (co_issue && h0_to_b);
        sel_b_valid = (h0_avail && h0_to_b)  || (co_issue && !h0_to_b);
        sel_a_ptr   = h0_to_b ? h1_ptr : head_q;
        sel_b_ptr   = h0_to_b ? head_q : h1_ptr;

        issue_en = !flush_i && !stop_i;
        if (issue_en) begin
            deq_n = CNT_W'(h0_avail) + CNT_W'(co_issue);
        end else begin
            deq_n = '0;
        end
    end

    // Enqueue control and next-state pointer/count arithmetic.
    always_comb begin
        enq_en  = in_ready_o && !flush_i;
        wr1     = enq_en && in1_valid_i;
        wr2     = enq_en && in2_valid_i;
        // A lone in2 takes the tail slot; behind in1 it takes the next one.
        wr2_ptr = in1_valid_i ? (tail_q + C_PTR_ONE) : tail_q;
        enq_n   = CNT_W'(wr1) + CNT_W'(wr2);

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + deq_n[PTR_W-1:0];
            tail_d  = tail_q + enq_n[PTR_W-1:0];
            count_d = count_q + enq_n - deq_n;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue entry storage, written in program order (in1 before in2).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                dec_q[i] <= '0;
                rd_q[i]  <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                we_q[i]  <= 1'b0;
                cls_q[i] <= '0;
            end
        end else begin
            if (wr1) begin
                pc_q[tail_q]  <= in1_pc_i;
                dec_q[tail_q] <= in1_dec_i;
                rd_q[tail_q]  <= in1_rd_i;
                rs1_q[tail_q] <= in1_rs1_i;
                rs2_q[tail_q] <= in1_rs2_i;
                we_q[tail_q]  <= in1_we_i;
                cls_q[tail_q] <= in1_cls_i;
            end
            if (wr2) begin
                pc_q[wr2_ptr]  <= in2_pc_i;
                dec_q[wr2_ptr] <= in2_dec_i;
                rd_q[wr2_ptr]  <= in2_rd_i;
                rs1_q[wr2_ptr] <= in2_rs1_i;
                rs2_q[wr2_ptr] <= in2_rs2_i;
                we_q[wr2_ptr]  <= in2_we_i;
                cls_q[wr2_ptr] <= in2_cls_i;
            end
        end
    end

    // Issue output registers: cleared by flush, frozen by stop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outa_valid_q <= 1'b0;
            outa_pc_q    <= '0;
            outa_dec_q   <= '0;
            outb_valid_q <= 1'b0;
            outb_pc_q    <= '0;
            outb_dec_q   <= '0;
            issue_flag_q <= '0;
        end else if (flush_i) begin
            outa_valid_q <= 1'b0;
            outb_valid_q <= 1'b0;
            issue_flag_q <= '0;
        end else if (!stop_i) begin
            outa_valid_q <= sel_a_valid;
            outb_valid_q <= sel_b_valid;
            issue_flag_q <= {co_issue, hazard, sel_b_valid, sel_a_valid};
            // Payload only moves when the pipe actually receives an entry.
            if (sel_a_valid) begin
                outa_pc_q  <= pc_q[sel_a_ptr];
                outa_dec_q <= dec_q[sel_a_ptr];
            end
            if (sel_b_valid) begin
                outb_pc_q  <= pc_q[sel_b_ptr];
                outb_dec_q <= dec_q[sel_b_ptr];
            end
        end
    end

    assign outa_valid_o = outa_valid_q;
    assign outa_pc_o    = outa_pc_q;
    assign outa_dec_o   = outa_dec_q;
    assign outb_valid_o = outb_valid_q;
    assign outb_pc_o    = outb_pc_q;
    assign outb_dec_o   = outb_dec_q;
    assign issue_flag_o = issue_flag_q;

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual_q;
    logic [31:0] stat_single_q;
    logic [31:0] stat_hazard_q;

    // Issue statistics: survive flush, wrap naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_dual_q   <= '0;
            stat_single_q <= '0;
            stat_hazard_q <= '0;
        end else if (issue_en) begin
            if (co_issue) begin
                stat_dual_q <= stat_dual_q + 32'd1;
            end
            if (h0_avail && !co_issue) begin
                stat_single_q <= stat_single_q + 32'd1;
            end
            if (hazard) begin
                stat_hazard_q <= stat_hazard_q + 32'd1;
            end
        end
    end

    assign stat_dual_o   = stat_dual_q;
    assign stat_single_o = stat_single_q;
    assign stat_hazard_o = stat_hazard_q;
`endif

endmodule
`default_nettype wire

// File: doc/issue_queue_dual.md
Name: issue_queue_dual

Overview:
- Parametrised successor to the two-slot launch selector.
- Buffers decoded instruction pairs in a DEPTH-entry in-order FIFO.
- Each cycle it picks up to two of the oldest entries and routes them to two execution pipes: A = ALU/branch, B = ALU/memory.
- Adds RAW and structural hazard checks, stall and flush handling, and registered issue outputs. Sits between decode and execute.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 4.
- PC_W, 32, PC width.
- DEC_W, 72, opaque decoded payload width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stop  in  1  downstream stall: freezes dequeue and output registers
- flush  in  1  pipeline flush (branch mispredict)
- in_ready  out  1  high when count <= DEPTH-2
- in1_valid, in2_valid  in  1 each  decode slot valid; in1 is older
- in1_pc, in2_pc  in  PC_W  instruction PC
- in1_dec, in2_dec  in  DEC_W  decoded payload
- in1_rd, in1_rs1, in1_rs2, in2_rd, in2_rs1, in2_rs2  in  5 each  register indices
- in1_we, in2_we  in  1 each  writes rd
- in1_cls, in2_cls  in  2 each  class: 0 = ALU, 1 = BR, 2 = MEM
- outa_valid, outb_valid  out  1 each  pipe A / pipe B issue valid
- outa_pc, outb_pc  out  PC_W  issued PC
- outa_dec, outb_dec  out  DEC_W  issued payload
- issue_flag  out  4  {dual, hazard, outb_valid, outa_valid}

Behaviour:
- Reset (rst=0, asynchronous): queue empty, pointers and count at 0, all out* and issue_flag at 0.
- Enqueue: only when in_ready=1. Valid slots are written in order, in1 then in2. If only in2 is valid it takes the single tail slot. Inputs presented while in_ready=0 are dropped; upstream must hold them.
- Count update: count += enq − deq. Simultaneous enqueue and dequeue are legal, including when count equals DEPTH-2.
- Pointer wrap-around uses a PTR_W-bit modulo DEPTH.
- Head pair: H0 is the oldest entry, H1 the next.
  - H0 is issued if count >= 1.
  - H1 is co-issued only if all of the following hold:
    - count >= 2;
    - no RAW: H0.we=1 and H0.rd≠0 and (H1.rs1==H0.rd or H1.rs2==H0.rd) blocks co-issue;
    - H0.cls ≠ BR (nothing issues behind a branch);
    - the two entries fit distinct pipes.
- Routing:
  - H0 goes to pipe A, unless H0 is MEM, in which case it goes to pipe B.
  - H1 takes the remaining pipe, and only if compatible: A accepts ALU/BR, B accepts ALU/MEM.
  - A BR in H1 can only go to A; a MEM in H1 can only go to B.
- hazard: 1 when count >= 2 and H1 was blocked for any reason. dual: 1 when two entries issue.
- Latency: outputs are registered. Entries selected in cycle N appear on out* in cycle N+1 with valid high for one cycle, unless stop=1.
- stop=1: no dequeue. out* and issue_flag hold their values. Enqueue still allowed.
- flush=1: highest priority. Next edge empties the queue, clears outa_valid, outb_valid and issue_flag, and drops same-cycle inputs. stop is ignored during flush.
- Payload and PC registers need not reset-clear beyond valid bits, but they do here for determinism.

Optional Feature:
- Macro ISSUE_STATS_EN.
- Defined:
  - adds outputs stat_dual (32 bit), stat_single (32 bit), stat_hazard (32 bit);
  - counters increment at each non-stop, non-flush edge that issues 2 entries, issues 1 entry, or sets hazard, respectively;
  - counters reset to 0 on rst, are not cleared by flush, and wrap at 2^32.
- Undefined: no stat ports or logic exist.

Test Plan:
- Reset, then write 2 independent ALU ops at PCs 0x00/0x04 with no stop → next cycle after dequeue: outa_pc=0x00, outb_pc=0x04, issue_flag=4'b1011.
- H0 is ALU with rd=5, H1 reads rs1=5 → only H0 issues on A, issue_flag=4'b0101; H1 issues alone on A the following cycle.
- H0=MEM at 0x10, H1=ALU at 0x14 → outb_pc=0x10, outa_pc=0x14. H0=BR then ALU → BR issues alone on A, hazard=1.
- Fill DEPTH=8 with stop=1 → in_ready drops when count=7; the next pair is not enqueued. Release stop → pairs drain in order across pointer wrap, with no loss and no duplication.
- flush asserted with 5 entries queued and valid outputs present → next cycle count=0, outa_valid=0, outb_valid=0, in_ready=1.
- Assert rst low mid-stream with outputs valid → outputs drop to 0 immediately (asynchronous) and the queue is empty after release. With ISSUE_STATS_EN defined: 3 dual issues plus 1 single issue give stat_dual=3 and stat_single=1.
